// File: rtl/frame_stream_pkg.sv
// Shared types for the frame-memory to pixel-stream transmit path.
package frame_stream_pkg;

   localparam int unsigned PIX_W     = 8;
   localparam int unsigned DEF_IMG_W = 512;
   localparam int unsigned DEF_IMG_H = 512;

   typedef logic [PIX_W-1:0] pix_t;

   // One stream beat as stored in the skid FIFO (10 bits).
   typedef struct packed {
      pix_t pix;
      logic sof;
      logic eol;
   } stream_beat_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_BLANK = 2'd2,
      ST_DRAIN = 2'd3
   } stream_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry shift FIFO of stream beats. The head always lives in entry 0,
// so the head output comes straight from a register and is zero when empty.
module pixel_skid_fifo
   import frame_stream_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  stream_beat_t beat_i,
   input  logic         pop_i,
   output stream_beat_t head_o,
   output logic [1:0]   count_o,
   output logic         empty_o,
   output logic         full_o
);

   stream_beat_t e0_q;
   stream_beat_t e1_q;
   logic [1:0]   count_q;
   logic         pop_eff;
   logic         push_eff;

   assign pop_eff  = pop_i & (count_q != 2'd0);
   assign push_eff = push_i & ((count_q != 2'd2) | pop_eff);

   // Storage shift and occupancy; vacated entries are cleared to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
      end else begin
         case ({push_eff, pop_eff})
            2'b10: begin
               if (count_q == 2'd0) e0_q <= beat_i;
               else                 e1_q <= beat_i;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               e0_q    <= (count_q == 2'd2) ? e1_q : '0;
               e1_q    <= '0;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  e0_q <= e1_q;
                  e1_q <= beat_i;
               end else begin
                  e0_q <= beat_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_o  = e0_q;
   assign count_o = count_q;
   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads a stored frame in raster order and emits it as a tagged pixel
// stream with credit-based flow control against downstream backpressure.
module frame_pixel_streamer
   import frame_stream_pkg::*;
#(
   parameter int unsigned IMG_W   = DEF_IMG_W,
   parameter int unsigned IMG_H   = DEF_IMG_H,
   parameter int unsigned H_BLANK = 0,
   parameter int unsigned ADDR_W  = $clog2(IMG_W*IMG_H)
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [7:0]        mem_rd_data,
   output logic [7:0]        pixel_out,
   output logic              pixel_out_valid,
   output logic              pixel_out_sof,
   output logic              pixel_out_eol,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned BLK_W     = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
   localparam int unsigned BLK_LAST  = (H_BLANK > 0) ? H_BLANK - 1 : 0;

   stream_state_t     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [BLK_W-1:0]  blank_q;
   logic              inflight_q;
   logic              tag_sof_q;
   logic              tag_eol_q;
   logic              busy_q;
   logic              done_q;

   stream_beat_t      fifo_head;
   stream_beat_t      fifo_beat;
   logic [1:0]        fifo_count;
   logic              fifo_empty;
   logic              fifo_full;

   logic              xfer;
   logic [2:0]        fill;
   logic              rd_en;
   logic              last_col;
   logic              last_row;
   logic              drain_done;

   assign xfer     = ~fifo_empty & out_ready;
   assign fill     = 3'(fifo_count) + 3'(inflight_q);
   assign last_col = (col_q == COL_W'(IMG_W - 1));
   assign last_row = (row_q == ROW_W'(IMG_H - 1));

   // Issue a read only while FIFO slots plus outstanding reads leave room.
   assign rd_en = (state_q == ST_READ) && ((fill - 3'(xfer)) < 3'd2)
                  && !(fifo_full && !xfer);

   // Finish once the FIFO empties this cycle and nothing is still in flight.
   assign drain_done = (state_q == ST_DRAIN) && !inflight_q &&
                       (fifo_empty || ((fifo_count == 2'd1) && xfer));

   // Sequencer: state, raster counters, read pipeline tags, status flags.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         blank_q    <= '0;
         inflight_q <= 1'b0;
         tag_sof_q  <= 1'b0;
         tag_eol_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= rd_en;
         tag_sof_q  <= rd_en & (addr_q == '0);
         tag_eol_q  <= rd_en & last_col;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_READ;
                  busy_q  <= 1'b1;
                  addr_q  <= '0;
                  col_q   <= '0;
                  row_q   <= '0;
               end
            end
            ST_READ: begin
               if (rd_en) begin
                  addr_q <= addr_q + ADDR_W'(1);
                  if (last_col) begin
                     col_q <= '0;
                     if (last_row) begin
                        state_q <= ST_DRAIN;
                     end else begin
                        row_q <= row_q + ROW_W'(1);
                        if (H_BLANK > 0) begin
                           state_q <= ST_BLANK;
                           blank_q <= '0;
                        end
                     end
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end
            end
            ST_BLANK: begin
               if (blank_q == BLK_W'(BLK_LAST)) state_q <= ST_READ;
               else                             blank_q <= blank_q + BLK_W'(1);
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fifo_beat = '{pix: mem_rd_data, sof: tag_sof_q, eol: tag_eol_q};

   pixel_skid_fifo u_fifo (
      .clk     (clk),
      .rst_n   (rstN),
      .push_i  (inflight_q),
      .beat_i  (fifo_beat),
      .pop_i   (xfer),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign mem_rd_en       = rd_en;
   assign mem_rd_addr     = addr_q;
   assign pixel_out       = fifo_head.pix;
   assign pixel_out_sof   = fifo_head.sof;
   assign pixel_out_eol   = fifo_head.eol;
   assign pixel_out_valid = ~fifo_empty;
   assign busy            = busy_q;
   assign frame_done      = done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed bench for frame_pixel_streamer on a 4x3 frame with mem[i]=i.
module tb_frame_pixel_streamer;

   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstN;
   logic          start1, ready1, start2, ready2;
   logic          rd1, rd2;
   logic [AW-1:0] addr1, addr2;
   logic [7:0]    rdata1, rdata2, pix1, pix2;
   logic          v1, sof1, eol1, busy1, done1;
   logic          v2, sof2, eol2, busy2, done2;

   // Synchronous-read frame memories holding mem[i] = i.
   always @(posedge clk) if (rd1) rdata1 <= 8'(addr1);
   always @(posedge clk) if (rd2) rdata2 <= 8'(addr2);

   frame_pixel_streamer #(.IMG_W(W), .IMG_H(H), .H_BLANK(0), .ADDR_W(AW)) dut1 (
      .clk(clk), .rstN(rstN), .start(start1),
      .mem_rd_en(rd1), .mem_rd_addr(addr1), .mem_rd_data(rdata1),
      .pixel_out(pix1), .pixel_out_valid(v1), .pixel_out_sof(sof1),
      .pixel_out_eol(eol1), .out_ready(ready1), .busy(busy1), .frame_done(done1));

   frame_pixel_streamer #(.IMG_W(W), .IMG_H(H), .H_BLANK(2), .ADDR_W(AW)) dut2 (
      .clk(clk), .rstN(rstN), .start(start2),
      .mem_rd_en(rd2), .mem_rd_addr(addr2), .mem_rd_data(rdata2),
      .pixel_out(pix2), .pixel_out_valid(v2), .pixel_out_sof(sof2),
      .pixel_out_eol(eol2), .out_ready(ready2), .busy(busy2), .frame_done(done2));

   typedef struct {
      logic        start;
      logic        rdy;
      logic [17:0] exp;   // {valid, pix, sof, eol, busy, done, rd_en, addr}
   } vec_t;

   vec_t tv[17];

   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   int   k, n, n2, dones, viol, stab_err, held5, outstanding, stall_left;
   logic ev, erd, got_done, found, stall_started, prev_stall, chk_next, xf;
   logic prev_sof, prev_eol;
   logic [7:0] prev_pix;
   int   pcyc[12];
   logic [9:0] pbeat[12];

   initial begin
      rstN = 1'b0; start1 = 1'b0; ready1 = 1'b1; start2 = 1'b0; ready2 = 1'b1;

      // Reset state
      #2;
      check("reset_dut1", 32'({rd1, v1, pix1, sof1, eol1, busy1, done1, addr1}), 32'd0);
      check("reset_dut2", 32'({rd2, v2, pix2, sof2, eol2, busy2, done2, addr2}), 32'd0);
      @(negedge clk); @(negedge clk);
      rstN = 1'b1;

      // Test 1: per-cycle table for one frame, no blanking, ready held high
      for (int c = 0; c < 17; c++) begin
         k   = c - 3;
         ev  = (c >= 3 && c <= 14);
         erd = (c >= 1 && c <= 12);
         tv[c].start = (c == 0);
         tv[c].rdy   = 1'b1;
         tv[c].exp   = {ev, ev ? 8'(k) : 8'd0, (ev && k == 0), (ev && (k % 4 == 3)),
                        (c >= 1 && c <= 14), (c == 15), erd, erd ? 4'(c - 1) : 4'd0};
      end
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         start1 = tv[c].start;
         ready1 = tv[c].rdy;
         #1;
         check($sformatf("t1_cyc%0d", c),
               32'({v1, pix1, sof1, eol1, busy1, done1, rd1, rd1 ? addr1 : 4'd0}),
               32'(tv[c].exp));
      end

      // Test 2: two blank cycles after each non-final line
      n2 = 0; got_done = 1'b0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      for (int c = 0; c < 80 && !got_done; c++) begin
         @(negedge clk); #1;
         if (v2) begin
            if (n2 < 12) begin
               pcyc[n2]  = c;
               pbeat[n2] = {pix2, sof2, eol2};
            end
            n2++;
         end
         if (done2) got_done = 1'b1;
      end
      check("t2_done", 32'(got_done), 32'd1);
      check("t2_count", 32'(n2), 32'd12);
      for (int i = 0; i < 12; i++)
         check($sformatf("t2_pix%0d", i), 32'(pbeat[i]),
               32'({8'(i), (i == 0), (i % 4 == 3)}));
      for (int i = 1; i < 12; i++)
         check($sformatf("t2_gap%0d", i), 32'(pcyc[i] - pcyc[i-1]),
               32'((i == 4 || i == 8) ? 3 : 1));

      // Test 3: 5-cycle stall at pixel 5, then random backpressure
      outstanding = 0; n = 0; viol = 0; stab_err = 0; held5 = 0; stall_left = 0;
      stall_started = 1'b0; prev_stall = 1'b0; got_done = 1'b0;
      prev_pix = 8'd0; prev_sof = 1'b0; prev_eol = 1'b0;
      for (int c = 0; c < 300 && !got_done; c++) begin
         @(negedge clk);
         start1 = (c == 0);
         if (!stall_started && v1 && pix1 == 8'd5) begin
            stall_started = 1'b1;
            stall_left    = 5;
         end
         if (stall_left > 0) begin
            ready1 = 1'b0;
            stall_left--;
         end else if (stall_started) begin
            ready1 = 1'($urandom_range(0, 1));
         end else begin
            ready1 = 1'b1;
         end
         #1;
         xf = v1 & ready1;
         if (rd1 && (outstanding - int'(xf)) >= 2) viol++;
         if (prev_stall && (!v1 || pix1 != prev_pix || sof1 != prev_sof || eol1 != prev_eol))
            stab_err++;
         if (v1 && !ready1 && pix1 == 8'd5) held5++;
         prev_stall = v1 & ~ready1;
         prev_pix = pix1; prev_sof = sof1; prev_eol = eol1;
         outstanding = outstanding + int'(rd1) - int'(xf);
         if (xf) begin
            check($sformatf("t3_pix%0d", n), 32'({pix1, sof1, eol1}),
                  32'({8'(n), (n == 0), (n % 4 == 3)}));
            n++;
         end
         if (done1) got_done = 1'b1;
      end
      ready1 = 1'b1;
      check("t3_done", 32'(got_done), 32'd1);
      check("t3_count", 32'(n), 32'd12);
      check("t3_credit_violations", 32'(viol), 32'd0);
      check("t3_stall_unstable", 32'(stab_err), 32'd0);
      check("t3_stall_hold5", 32'(held5 >= 5), 32'd1);

      // Test 4a: a start pulse mid-frame is ignored
      n = 0; got_done = 1'b0;
      for (int c = 0; c < 100 && !got_done; c++) begin
         @(negedge clk);
         start1 = (c == 0 || c == 6);
         #1;
         if (v1) n++;
         if (done1) got_done = 1'b1;
      end
      start1 = 1'b0;
      check("t4_first_count", 32'(n), 32'd12);
      repeat (5) @(negedge clk);
      #1;
      check("t4_ignored_start", 32'({busy1, v1}), 32'd0);

      // Test 4b: start held high for two back-to-back frames
      n = 0; dones = 0; chk_next = 1'b0;
      for (int c = 0; c < 150 && dones < 2; c++) begin
         @(negedge clk);
         start1 = (dones == 0);
         #1;
         if (chk_next) begin
            check("t4_idle_one_cycle", 32'(busy1), 32'd1);
            chk_next = 1'b0;
         end
         if (v1) begin
            check($sformatf("t4_pix%0d", n), 32'({pix1, sof1}),
                  32'({8'(n % 12), (n % 12 == 0)}));
            n++;
         end
         if (done1) begin
            dones++;
            if (dones == 1) chk_next = 1'b1;
         end
      end
      start1 = 1'b0;
      check("t4_total_pixels", 32'(n), 32'd24);
      check("t4_done_pulses", 32'(dones), 32'd2);
      repeat (3) @(negedge clk);
      #1;
      check("t4_no_third_frame", 32'({busy1, v1}), 32'd0);

      // Test 5: asynchronous reset while pixel 6 is valid
      found = 1'b0;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk); #1;
         if (v1 && pix1 == 8'd6) found = 1'b1;
      end
      check("t5_reach_pix6", 32'(found), 32'd1);
      #2 rstN = 1'b0;
      #1;
      check("t5_async_clear", 32'({rd1, v1, pix1, sof1, eol1, busy1, done1, addr1}), 32'd0);
      @(negedge clk); rstN = 1'b1;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk); #1;
         if (v1) begin
            check("t5_restart_pix", 32'({pix1, sof1}), 32'({8'd0, 1'b1}));
            found = 1'b1;
         end
      end
      check("t5_restart_seen", 32'(found), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
